// File: rtl/alu16_sequencer_pkg.sv
// alu_pkg: shared opcodes, FSM encoding and widths for the 16-bit ALU sequencer.
package alu_pkg;
    localparam int DATA_W = 16;
    localparam int ALU_W = 8;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SHR = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOT = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
endpackage

// File: rtl/alu16_sequencer_if.sv
// alu16_sequencer_if: operand-in and result-out valid/ready channels of the sequencer.
interface alu16_sequencer_if;
    import alu_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [2:0] in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic out_valid;
    logic out_ready;
    logic [DATA_W-1:0] out_result;
    logic out_carry;
    logic out_zero;
    modport master(output in_valid, in_op, in_a, in_b, out_ready,
                   input in_ready, out_valid, out_result, out_carry, out_zero);
    modport slave(input in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_result, out_carry, out_zero);
endinterface

// File: rtl/alu16_sequencer_alu.sv
// alu: 8-bit combinational ALU; carry is only meaningful for ADD/SUB/shift ops.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]       op_i,
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    output logic [ALU_W-1:0] y_o,
    output logic             carry_o
);
    logic [ALU_W:0] sum, diff;
    assign sum = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    always_comb begin
        y_o = a_i ^ b_i;
        carry_o = 1'b0;
        case (op_i)
            ALU_ADD: {carry_o, y_o} = sum;
            ALU_SUB: {carry_o, y_o} = diff;
            ALU_SHR: {y_o, carry_o} = {1'b0, a_i};
            ALU_SHL: {carry_o, y_o} = {a_i, 1'b0};
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_NOT: y_o = ~a_i;
            default: y_o = a_i ^ b_i;
        endcase
    end
endmodule

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: 16-bit ALU op built from two time-shared 8-bit passes, low byte first.
module alu16_sequencer
    import alu_pkg::*;
(
    input logic clk,
    input logic rst,
    alu16_sequencer_if.slave io
);
    state_t state_q, state_d;
    logic [2:0] op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [ALU_W-1:0] lo_q, lo_d, hi_d, alu_a, alu_b, alu_y;
    logic c_q, c_d, carry_q, carry_d, zero_q, alu_c;

    assign alu_a = state_q == HI ? a_q[15:8] : a_q[7:0];
    assign alu_b = state_q == HI ? b_q[15:8] : b_q[7:0];

    alu u_alu (.op_i(op_q), .a_i(alu_a), .b_i(alu_b), .y_o(alu_y), .carry_o(alu_c));

    // Chain bit c bridges the passes: ADD carry, SUB borrow; shifts inject the neighbour byte's bit.
    always_comb begin
        state_d = state_q;
        lo_d = op_q == ALU_SHR ? {a_q[8], alu_y[6:0]} : alu_y;
        c_d = op_q == ALU_ADD ? alu_c : op_q == ALU_SUB ? a_q[7:0] < b_q[7:0] : 1'b0;
        hi_d = op_q == ALU_ADD ? alu_y + {7'b0, c_q} :
               op_q == ALU_SUB ? alu_y - {7'b0, c_q} :
               op_q == ALU_SHL ? {alu_y[7:1], a_q[7]} : alu_y;
        carry_d = op_q == ALU_ADD ? alu_c | (&alu_y & c_q) :
                  op_q == ALU_SUB ? a_q < b_q :
                  op_q == ALU_SHR ? a_q[0] :
                  op_q == ALU_SHL ? a_q[15] : 1'b0;
        state_d = state_q == IDLE ? (io.in_valid ? LO : IDLE) :
                  state_q == LO ? HI :
                  state_q == HI ? DONE : (io.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q <= '0;
            carry_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && io.in_valid) begin
                op_q <= io.in_op;
                a_q <= io.in_a;
                b_q <= io.in_b;
            end
            if (state_q == LO) begin
                lo_q <= lo_d;
                c_q <= c_d;
            end
            if (state_q == HI) begin
                res_q <= {hi_d, lo_q};
                carry_q <= carry_d;
                zero_q <= {hi_d, lo_q} == '0;
            end
        end
    end

    assign io.in_ready = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.out_result = res_q;
    assign io.out_carry = carry_q;
    assign io.out_zero = zero_q;
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: directed and random ops against a 16-bit arithmetic reference model.
module tb_alu16_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    alu16_sequencer_if bus();
    alu16_sequencer dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {a < b, 16'(a - b)};
            3'd2: return {a[0], 16'(a >> 1)};
            3'd3: return {a[15], 16'(a << 1)};
            3'd4: return {1'b0, a & b};
            3'd5: return {1'b0, a | b};
            3'd6: return {1'b0, ~a};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [16:0] exp;
        int n;
        exp = model(op, a, b);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        bus.out_ready = hold == 0;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a = 16'($urandom);
        bus.in_b = 16'($urandom);
        bus.in_op = 3'($urandom);
        n = 1;
        while (!bus.out_valid && n < 10) begin
            check("in_ready_busy", bus.in_ready, 0);
            tick();
            n++;
        end
        check("latency", n, 3);
        check("result", bus.out_result, exp[15:0]);
        check("carry", bus.out_carry, exp[16]);
        check("zero", bus.out_zero, exp[15:0] == 16'h0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", bus.out_valid, 1);
            check("hold_ready", bus.in_ready, 0);
            check("hold_result", {bus.out_carry, bus.out_result}, exp);
            if (i == hold - 1) bus.out_ready = 1'b1;
        end
        tick();
        check("post_valid", bus.out_valid, 0);
        check("post_ready", bus.in_ready, 1);
        check("post_result", {bus.out_carry, bus.out_result}, exp);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op = 3'd0;
        bus.in_a = 16'h0;
        bus.in_b = 16'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_ready", bus.in_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_outs", {bus.out_zero, bus.out_carry, bus.out_result}, 18'h0);

        run_op(3'd0, 16'h00FF, 16'h0001, 0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 0);
        run_op(3'd1, 16'h0100, 16'h0001, 0);
        run_op(3'd1, 16'h0001, 16'h0002, 0);
        run_op(3'd2, 16'h0101, 16'h1234, 0);
        run_op(3'd3, 16'h8080, 16'h4321, 0);
        run_op(3'd7, 16'hA5A5, 16'hA5A5, 0);
        run_op(3'd6, 16'h00FF, 16'($urandom), 0);
        run_op(3'd0, 16'h12FF, 16'h3401, 5);
        run_op(3'd4, 16'hF0F0, 16'h3C3C, 1);

        // Abort an op in its HI pass; it must never surface.
        bus.in_valid = 1'b1;
        bus.in_op = 3'd5;
        bus.in_a = 16'h1111;
        bus.in_b = 16'h2222;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", bus.in_ready, 1);
        check("abort_valid", bus.out_valid, 0);
        check("abort_outs", {bus.out_zero, bus.out_carry, bus.out_result}, 18'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_quiet", bus.out_valid, 0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFF;
            run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
